hdr_queue_ctrl: RTL and testbench
=================================

// Module: hdr_queue_ctrl
// PURPOSE
//  Sequencer/arbiter for the 16x32 header RAM (hdrram) in comp_unit. Treats the RAM as a 16-entry
//  circular queue. Two header producers share it: req0 = compressor header, req1 = DMA descriptor.
//  Producers are arbitrated round-robin at packet granularity; one consumer drains via valid/ready.
//  hdrram is instantiated by the parent. This block drives its write port (addr0/we/data0_in) and
//  its async read address (addr1), and takes data1_out back as ram_rdata.
// PARAMETERS
//  DW     32  header word width; must match hdrram
//  AW     4   RAM address width; depth = 2**AW = 16
// PORTS
//  clk          in   1     single clock, also hdrram WCLK
//  rst_n        in   1     asynchronous reset, active low
//  flush        in   1     sync clear: empties queue, drops any locked packet
//  req0_valid   in   1     producer 0 word valid
//  req0_data    in   DW    producer 0 word
//  req0_last    in   1     last word of producer 0 packet
//  req0_ready   out  1     producer 0 word accepted when valid&ready
//  req1_valid   in   1     producer 1 word valid
//  req1_data    in   DW    producer 1 word
//  req1_last    in   1     last word of producer 1 packet
//  req1_ready   out  1     producer 1 word accepted when valid&ready
//  out_valid    out  1     queue head valid
//  out_data     out  DW    queue head word (= ram_rdata)
//  out_last     out  1     queue head is the last word of its packet
//  out_src      out  1     producer id of the queue head
//  out_ready    in   1     consumer pops the head when out_valid&out_ready
//  ram_waddr    out  AW    -> hdrram addr0
//  ram_we       out  1     -> hdrram we
//  ram_wdata    out  DW    -> hdrram data0_in
//  ram_raddr    out  AW    -> hdrram addr1
//  ram_rdata    in   DW    <- hdrram data1_out (combinational read)
//  count        out  AW+1  occupancy, 0..16
//  full         out  1     count==16
//  empty        out  1     count==0
// BEHAVIOUR
//  Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, lock=0, gnt=0, last_gnt=1
//   (so req0 wins first), req*_ready=0, ram_we=0, out_valid=0. The last/src side arrays are not reset.
//  Arbiter, evaluated combinationally each cycle:
//   - lock=1: gnt is held.
//   - lock=0, one requester valid: that requester is granted.
//   - lock=0, both valid: the requester != last_gnt is granted.
//  reqN_ready = !full & !flush & (gnt==N) & (lock | reqN_valid).
//   - The ungranted requester always sees ready=0.
//  On accept: ram_we=1, ram_waddr=wr_ptr, ram_wdata=selected data (combinational, same cycle).
//   - Side flops last_mem[wr_ptr] and src_mem[wr_ptr] are written.
//   - wr_ptr++ (wraps 15->0).
//   - Non-last word: lock<=1, gnt held. Last word: lock<=0, last_gnt<=gnt.
//  Read side:
//   - ram_raddr=rd_ptr; out_data=ram_rdata; out_last=last_mem[rd_ptr]; out_src=src_mem[rd_ptr].
//   - out_valid=!empty. Pop when out_valid&out_ready: rd_ptr++ (wraps).
//  Latency: word accepted at edge k is visible at out_* after edge k (one clock). No write->read bypass.
//  count: +1 on accept only; -1 on pop only; unchanged on simultaneous accept and pop.
//   - full/empty are registered, derived from next count.
//  Full: no accept, even if a pop occurs the same cycle; the slot frees next cycle.
//  Empty: pops are ignored (out_valid=0).
//  Locked producer idle mid-packet (valid=0): lock is held. The other producer waits; no timeout.
//  flush=1 has priority over accept and pop. It sets pointers, count, lock to 0 and empty=1;
//   last_gnt is kept. Data already written to the RAM is abandoned.
//  Asserting rst_n low mid-packet: all state clears immediately. The producer must restart its packet.
// STRUCTURE
//  Shared package (comp_unit_pkg): HDR_DW=32, HDR_AW=4, SRC_COMP=1'b0, SRC_DMA=1'b1.
//  One sub-module: hdr_rr_arb2. It holds the packet-locked 2-way round-robin
//   (inputs valid[1:0], last, accept; outputs gnt, lock).
//  Pointers, count and side arrays live in the top of this block. The RAM stays outside.
// TESTING
//  1. After reset, req0 pushes 0xA0000001 (last) -> ram_we at addr 0; next cycle out_valid=1,
//     out_data=0xA0000001, out_src=0, count=1.
//  2. Both valid from reset; req0 sends 3-word packet, req1 sends 2-word packet
//     -> queue order r0,r0,r0,r1,r1; req1_ready=0 until req0_last is accepted.
//  3. Both hold single-word packets continuously, out_ready=1 -> grants alternate 0,1,0,1;
//     count stays <=1.
//  4. Push 16 words with out_ready=0 -> full=1, both ready=0.
//     Pop one while req0 is valid -> no accept that cycle; accept next cycle at addr 0 (wrap); count=16.
//  5. Mid-packet (lock=1, 2 words queued), flush=1 -> count=0, empty=1, lock=0;
//     req1 is granted the next cycle.
//  6. Drop rst_n asynchronously mid-packet with count=5 -> outputs reach reset values
//     before the next clk edge; queue resumes at addr 0 after release.

Source files
------------

// File: rtl/comp_unit_pkg.sv
// Shared constants for comp_unit: header RAM geometry and producer ids.
package comp_unit_pkg;
  localparam int unsigned HDR_DW = 32;
  localparam int unsigned HDR_AW = 4;
  localparam logic SRC_COMP = 1'b0;
  localparam logic SRC_DMA  = 1'b1;
endpackage

// File: rtl/hdr_rr_arb2.sv
// Two-way round-robin arbiter that holds its grant until the granted producer sends its last word.
module hdr_rr_arb2
  import comp_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       accept,
  output logic       gnt,
  output logic       lock
);

  logic gnt_q, lock_q, last_gnt_q;

  always_comb begin
    gnt = gnt_q;
    if (!lock_q) begin
      unique case (valid)
        2'b01:   gnt = SRC_COMP;
        2'b10:   gnt = SRC_DMA;
        2'b11:   gnt = ~last_gnt_q;
        default: gnt = gnt_q;
      endcase
    end
  end

  assign lock = lock_q;

  // last_gnt starts at DMA so the compressor wins the first contended packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= 1'b0;
      lock_q     <= 1'b0;
      last_gnt_q <= 1'b1;
    end else if (flush) begin
      gnt_q  <= gnt;
      lock_q <= 1'b0;
    end else begin
      gnt_q <= gnt;
      if (accept) begin
        lock_q <= ~last;
        if (last) last_gnt_q <= gnt;
      end
    end
  end

endmodule

// File: rtl/hdr_queue_ctrl.sv
// Header RAM sequencer: 16-entry circular queue fed by two packet producers, drained by one consumer.
module hdr_queue_ctrl
  import comp_unit_pkg::*;
#(
  parameter int unsigned DW = HDR_DW,
  parameter int unsigned AW = HDR_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  input  logic          req0_last,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  input  logic          req1_last,
  output logic          req1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_src,
  input  logic          out_ready,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] FullCount = (AW + 1)'(Depth);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          last_mem [Depth];
  logic          src_mem  [Depth];

  logic          gnt, lock, can_accept, accept, pop;
  logic          sel_valid, sel_last;
  logic [DW-1:0] sel_data;

  hdr_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .valid  ({req1_valid, req0_valid}),
    .last   (sel_last),
    .accept (accept),
    .gnt    (gnt),
    .lock   (lock)
  );

  assign sel_valid = gnt ? req1_valid : req0_valid;
  assign sel_data  = gnt ? req1_data  : req0_data;
  assign sel_last  = gnt ? req1_last  : req0_last;

  // rst_n term keeps ready low while reset is held, independent of producer inputs.
  assign can_accept = rst_n & ~full_q & ~flush;
  assign req0_ready = can_accept & ~gnt & (lock | req0_valid);
  assign req1_ready = can_accept &  gnt & (lock | req1_valid);
  assign accept     = sel_valid & (gnt ? req1_ready : req0_ready);
  assign pop        = ~empty_q & out_ready & ~flush;

  assign ram_we    = accept;
  assign ram_waddr = wr_ptr_q;
  assign ram_wdata = sel_data;
  assign ram_raddr = rd_ptr_q;

  assign out_valid = ~empty_q;
  assign out_data  = ram_rdata;
  assign out_last  = last_mem[rd_ptr_q];
  assign out_src   = src_mem[rd_ptr_q];

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

  always_comb begin
    count_d = count_q;
    if (flush)              count_d = '0;
    else if (accept && !pop) count_d = count_q + 1'b1;
    else if (pop && !accept) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == FullCount);
      empty_q <= (count_d == '0);
    end
  end

  // Side arrays travel with the RAM contents, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      last_mem[wr_ptr_q] <= sel_last;
      src_mem[wr_ptr_q]  <= gnt;
    end
  end

endmodule

// File: tb/tb_hdr_queue_ctrl.sv
// Bench for hdr_queue_ctrl: directed tables, corner sequences and a randomized queue-model run.
module tb_hdr_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_last, out_src;
  logic        out_ready = 1'b0;
  logic [31:0] out_data, ram_wdata, ram_rdata;
  logic [3:0]  ram_waddr, ram_raddr;
  logic        ram_we;
  logic [4:0]  count;
  logic        full, empty;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  hdr_queue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .ram_waddr  (ram_waddr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue of entries plus the packet owner and last finished owner.
  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        s;
  } ent_t;

  ent_t mq[$];
  int   owner;
  int   prev;
  int   wp, rp;
  bit   p_acc, p_pop, p_fl;
  int   p_g;
  ent_t p_ent;

  task automatic model_reset();
    mq.delete();
    owner = -1;
    prev  = 1;
    wp    = 0;
    rp    = 0;
  endtask

  task automatic apply(input bit v0, input logic [31:0] d0, input bit l0,
                       input bit v1, input logic [31:0] d1, input bit l1,
                       input bit fl, input bit ord);
    bit fullm, ok, e_r0, e_r1;
    int g;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1;
    flush = fl; out_ready = ord;
    #1;
    fullm = (mq.size() == 16);
    ok    = !fullm && !fl;
    if (owner >= 0)    g = owner;
    else if (v0 && v1) g = 1 - prev;
    else if (v1)       g = 1;
    else               g = 0;
    e_r0  = ok && g == 0 && (owner == 0 || v0);
    e_r1  = ok && g == 1 && (owner == 1 || v1);
    p_acc = (g == 0) ? (v0 && e_r0) : (v1 && e_r1);
    p_pop = mq.size() > 0 && ord && !fl;
    p_fl  = fl;
    p_g   = g;
    p_ent.d = (g == 0) ? d0 : d1;
    p_ent.l = (g == 0) ? l0 : l1;
    p_ent.s = g[0];
    chk("m_ready0", req0_ready, e_r0);
    chk("m_ready1", req1_ready, e_r1);
    chk("m_we", ram_we, p_acc);
    if (p_acc) begin
      chk("m_waddr", ram_waddr, wp);
      chk("m_wdata", ram_wdata, p_ent.d);
    end
    chk("m_raddr", ram_raddr, rp);
    chk("m_count", count, mq.size());
    chk("m_full", full, fullm);
    chk("m_empty", empty, mq.size() == 0);
    chk("m_out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("m_out_data", out_data, mq[0].d);
      chk("m_out_last", out_last, mq[0].l);
      chk("m_out_src", out_src, mq[0].s);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (p_fl) begin
      mq.delete();
      wp = 0;
      rp = 0;
      owner = -1;
    end else begin
      if (p_pop) begin
        void'(mq.pop_front());
        rp = (rp + 1) % 16;
      end
      if (p_acc) begin
        mq.push_back(p_ent);
        wp = (wp + 1) % 16;
        if (p_ent.l) begin
          owner = -1;
          prev  = p_g;
        end else begin
          owner = p_g;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_last = 0; req1_last = 0;
    req0_data = '0; req1_data = '0; flush = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v0; logic [31:0] d0; bit l0;
    bit v1; logic [31:0] d1; bit l1;
    bit ordy;
    bit e_r0, e_r1, e_we; int e_wa;
    bit e_ov; logic [31:0] e_od; bit e_src; int e_cnt;
  } vec_t;

  vec_t tv[11];

  initial begin
    model_reset();
    do_reset();

    // Single-word push from reset, one-clock visibility.
    apply(1, 32'hA0000001, 1, 0, '0, 0, 0, 0);
    chk("t1_we", ram_we, 1);
    chk("t1_waddr", ram_waddr, 0);
    chk("t1_empty_rst", empty, 1);
    tick();
    apply(0, '0, 0, 0, '0, 0, 0, 0);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 32'hA0000001);
    chk("t1_out_src", out_src, 0);
    chk("t1_count", count, 1);
    tick();

    // Contended packets: r0 3 words then r1 2 words, then drain.
    do_reset();
    tv[0]  = '{1, 32'h10000001, 0, 1, 32'h20000001, 0, 0, 1, 0, 1, 0, 0, 32'h0, 0, 0};
    tv[1]  = '{1, 32'h10000002, 0, 1, 32'h20000001, 0, 0, 1, 0, 1, 1, 1, 32'h10000001, 0, 1};
    tv[2]  = '{1, 32'h10000003, 1, 1, 32'h20000001, 0, 0, 1, 0, 1, 2, 1, 32'h10000001, 0, 2};
    tv[3]  = '{0, 32'h0, 0, 1, 32'h20000001, 0, 0, 0, 1, 1, 3, 1, 32'h10000001, 0, 3};
    tv[4]  = '{0, 32'h0, 0, 1, 32'h20000002, 1, 0, 0, 1, 1, 4, 1, 32'h10000001, 0, 4};
    tv[5]  = '{0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 32'h10000001, 0, 5};
    tv[6]  = '{0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 32'h10000002, 0, 4};
    tv[7]  = '{0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 32'h10000003, 0, 3};
    tv[8]  = '{0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 32'h20000001, 1, 2};
    tv[9]  = '{0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 32'h20000002, 1, 1};
    tv[10] = '{0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      apply(tv[i].v0, tv[i].d0, tv[i].l0, tv[i].v1, tv[i].d1, tv[i].l1, 0, tv[i].ordy);
      chk($sformatf("t2_r0_%0d", i), req0_ready, tv[i].e_r0);
      chk($sformatf("t2_r1_%0d", i), req1_ready, tv[i].e_r1);
      chk($sformatf("t2_we_%0d", i), ram_we, tv[i].e_we);
      if (tv[i].e_we) chk($sformatf("t2_wa_%0d", i), ram_waddr, tv[i].e_wa);
      chk($sformatf("t2_ov_%0d", i), out_valid, tv[i].e_ov);
      if (tv[i].e_ov) begin
        chk($sformatf("t2_od_%0d", i), out_data, tv[i].e_od);
        chk($sformatf("t2_src_%0d", i), out_src, tv[i].e_src);
      end
      chk($sformatf("t2_cnt_%0d", i), count, tv[i].e_cnt);
      tick();
    end

    // Alternating single-word packets with continuous drain.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(1, 32'hB0000000 + i, 1, 1, 32'hC0000000 + i, 1, 0, 1);
      chk("t3_gnt1", req1_ready, i % 2);
      chk("t3_gnt0", req0_ready, (i + 1) % 2);
      chk("t3_cnt_le1", count <= 1, 1);
      tick();
    end

    // Fill, pop while full, accept wraps to address 0.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(1, 32'hD0000000 + i, 1, 0, '0, 0, 0, 0);
      tick();
    end
    apply(1, 32'hDEAD0000, 1, 1, 32'hDEAD0001, 1, 0, 0);
    chk("t4_full", full, 1);
    chk("t4_r0_full", req0_ready, 0);
    chk("t4_r1_full", req1_ready, 0);
    tick();
    apply(1, 32'hD0000010, 1, 0, '0, 0, 0, 1);
    chk("t4_no_acc_on_pop", ram_we, 0);
    tick();
    apply(1, 32'hD0000010, 1, 0, '0, 0, 0, 0);
    chk("t4_acc_we", ram_we, 1);
    chk("t4_acc_wrap", ram_waddr, 0);
    tick();
    apply(0, '0, 0, 0, '0, 0, 0, 0);
    chk("t4_count16", count, 16);
    chk("t4_full_again", full, 1);
    tick();

    // Flush mid-packet releases the lock; round-robin favours req1 afterwards.
    do_reset();
    apply(1, 32'hE0000000, 1, 0, '0, 0, 0, 0); tick();
    apply(1, 32'hE0000001, 0, 0, '0, 0, 0, 0); tick();
    apply(1, 32'hE0000002, 0, 0, '0, 0, 0, 0); tick();
    apply(1, 32'hE0000003, 0, 1, 32'hF0000000, 1, 1, 0);
    chk("t5_flush_r0", req0_ready, 0);
    chk("t5_flush_we", ram_we, 0);
    tick();
    apply(1, 32'hE0000003, 0, 1, 32'hF0000000, 1, 0, 0);
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_r1", req1_ready, 1);
    chk("t5_r0", req0_ready, 0);
    tick();

    // Asynchronous reset mid-packet.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1, 32'h50000000 + i, 0, 0, '0, 0, 0, 0);
      tick();
    end
    apply(1, 32'h50000005, 0, 0, '0, 0, 0, 0);
    chk("t6_count5", count, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_full", full, 0);
    chk("t6_rst_ov", out_valid, 0);
    chk("t6_rst_r0", req0_ready, 0);
    chk("t6_rst_we", ram_we, 0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 32'h60000000, 1, 0, '0, 0, 0, 0);
    chk("t6_resume_addr", ram_waddr, 0);
    chk("t6_resume_we", ram_we, 1);
    tick();

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      apply($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) == 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
